score_keeper: RTL and testbench
===============================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter TIMEOUT_TICKS, default 2000: tick strobes allowed per goal note before a timeout miss.
REQ-002 Parameter HIT_PTS, default 2: points awarded per hit.
REQ-003 Parameter SCORE_W, default 10: width of the score output.
REQ-004 Ports SHALL be, clock and reset first: clk in 1, rising-edge clock; rst in 1, reset, synchronous, active-high.
REQ-005 en in 1: study mode active; a rising edge starts a session.
REQ-006 tick in 1: 1 ms single-cycle strobe.
REQ-007 key_vld in 1: single-cycle player key event; key_oct in OCTAVE_BITS; key_note in NOTE_BITS, where 0 means rest.
REQ-008 goal_vld in 1: goal presented, held until advance; goal_oct in OCTAVE_BITS; goal_note in NOTE_BITS; goal_last in 1: final note of song.
REQ-009 advance out 1: single-cycle request to the song sequencer to step its note counter.
REQ-010 judge_hit out 1 and judge_miss out 1: single-cycle result strobes, mutually exclusive.
REQ-011 score out SCORE_W, streak out 4, grade out 2 (3=A, 0=D), done out 1 (level).

Function
REQ-012 FSM states SHALL be IDLE, WAIT_GOAL, ARMED, RESULT, DONE.
REQ-013 IDLE: en rising edge -> WAIT_GOAL; score, streak, note_cnt and miss_cnt clear; done deasserts.
REQ-014 WAIT_GOAL: goal_vld high -> latch the goal fields, clear the window counter, go to ARMED next cycle.
REQ-015 Key events and ticks SHALL be ignored in WAIT_GOAL.
REQ-016 ARMED, non-rest goal, key_vld with a matching note -> hit, then RESULT.
REQ-017 ARMED, non-rest goal, key_vld with a mismatched note -> judge_miss, miss_cnt+1, streak cleared, remain ARMED (retry); the window counter is not reset.
REQ-018 ARMED, rest goal: any key_vld -> miss, then RESULT; reaching timeout -> hit, then RESULT.
REQ-019 ARMED, non-rest goal: the window counter increments per tick; reaching TIMEOUT_TICKS -> miss, then RESULT.
REQ-020 key_vld and timeout in the same cycle: the key event is judged; the timeout is discarded.
REQ-021 Hit: judge_hit, streak+1 saturating at 15, score += HIT_PTS, plus 1 bonus if streak was >=4 before the increment.
REQ-022 Score SHALL saturate at 2^SCORE_W-1 and never wrap.
REQ-023 Miss leading to RESULT: judge_miss, streak=0, miss_cnt+1.
REQ-024 Result strobes assert in the cycle after the deciding input.
REQ-025 RESULT (one cycle): advance=1, note_cnt+1; if goal_last -> DONE, else -> WAIT_GOAL.
REQ-026 DONE: done=1 and grade computed once on entry, then held: miss_cnt==0 -> 3; miss_cnt<=note_cnt>>3 -> 2; miss_cnt<=note_cnt>>2 -> 1; else 0.
REQ-027 note_cnt and miss_cnt SHALL be 8 bits, saturating.
REQ-028 en low in any state -> IDLE next cycle, no advance, score and grade retained for display.
REQ-029 A new en rising edge restarts the session per REQ-013.

Reset
REQ-030 rst SHALL force IDLE; advance, judge_hit, judge_miss, done = 0; score, streak, grade, all counters = 0.
REQ-031 rst SHALL take priority over every other input in the same cycle, including mid-window.

Configuration
REQ-032 With SCORE_OCTAVE_MATCH_EN defined, a match requires key_note==goal_note AND key_oct==goal_oct.
REQ-033 Without SCORE_OCTAVE_MATCH_EN, a match requires key_note==goal_note only; key_oct is unused.

Structure
REQ-034 OCTAVE_BITS, NOTE_BITS, the REST note code and the grade encodings SHALL live in the shared constants package, the same one already used by the key-input and sound stages.
REQ-035 One sub-module, score_grade (combinational grade from note_cnt/miss_cnt), SHALL be used; all other logic is flat.

Verification
REQ-036 Clean run: 3 goals (note 1,3,5; last on 5), matching key each -> 3 judge_hit, score=6, streak=3, advance x3, done=1, grade=3.
REQ-037 Wrong then right: goal 4, key 2 then key 4 -> judge_miss then judge_hit, one advance only, miss_cnt=1, streak=1.
REQ-038 Timeout: TIMEOUT_TICKS=5, no key, 5 ticks -> judge_miss on the 5th, advance; rest goal with same stimulus -> judge_hit.
REQ-039 Streak bonus and saturation: SCORE_W=4, 6 consecutive hits -> score 2,4,6,8,11,14, then the 7th hit saturates at 15.
REQ-040 Collision: key_vld matching and the 5th tick in the same cycle -> judge_hit only.
REQ-041 Abort: en low while ARMED -> IDLE, no advance; rst mid-window -> all outputs 0 next cycle.
REQ-042 Octave-match config: with SCORE_OCTAVE_MATCH_EN, key note 3 oct 5 vs goal note 3 oct 4 -> miss; without the macro -> hit.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// Shared note/octave widths, rest code and grade encodings.
// Also holds the score_keeper state type and a saturating counter helper.
package score_keeper_pkg;

    localparam int OCTAVE_BITS = 3;
    localparam int NOTE_BITS   = 4;
    localparam int CNT_W       = 8;

    localparam logic [NOTE_BITS-1:0] NOTE_REST = '0;

    typedef enum logic [1:0] {
        GRADE_D = 2'd0,
        GRADE_C = 2'd1,
        GRADE_B = 2'd2,
        GRADE_A = 2'd3
    } grade_e;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GOAL,
        ARMED,
        RESULT,
        DONE
    } sk_state_e;

    function automatic logic [CNT_W-1:0] sat_inc8(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/score_grade.sv
// Letter grade from the count of notes played and notes missed.
module score_grade
    import score_keeper_pkg::*;
(
    input  logic [CNT_W-1:0] note_cnt,
    input  logic [CNT_W-1:0] miss_cnt,
    output grade_e           grade
);

    always_comb begin
        grade = GRADE_D;
        if (miss_cnt == '0) begin
            grade = GRADE_A;
        end else if (miss_cnt <= (note_cnt >> 3)) begin
            grade = GRADE_B;
        end else if (miss_cnt <= (note_cnt >> 2)) begin
            grade = GRADE_C;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Study-mode judge: compares player keys to the goal note and keeps score.
// Define SCORE_OCTAVE_MATCH_EN to require the octave to match as well.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 2000,
    parameter int HIT_PTS       = 2,
    parameter int SCORE_W       = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   tick,
    input  logic                   key_vld,
    input  logic [OCTAVE_BITS-1:0] key_oct,
    input  logic [NOTE_BITS-1:0]   key_note,
    input  logic                   goal_vld,
    input  logic [OCTAVE_BITS-1:0] goal_oct,
    input  logic [NOTE_BITS-1:0]   goal_note,
    input  logic                   goal_last,
    output logic                   advance,
    output logic                   judge_hit,
    output logic                   judge_miss,
    output logic [SCORE_W-1:0]     score,
    output logic [3:0]             streak,
    output logic [1:0]             grade,
    output logic                   done
);

    localparam int WIN_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(TIMEOUT_TICKS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    sk_state_e              state_q, state_d;
    logic                   en_prev_q;
    logic [WIN_W-1:0]       win_q, win_d;
    logic [NOTE_BITS-1:0]   goal_note_q, goal_note_d;
    logic [OCTAVE_BITS-1:0] goal_oct_q, goal_oct_d;
    logic                   goal_last_q, goal_last_d;
    logic [CNT_W-1:0]       note_cnt_q, note_cnt_d;
    logic [CNT_W-1:0]       miss_cnt_q, miss_cnt_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic [3:0]             streak_q, streak_d;
    grade_e                 grade_q, grade_d;
    logic                   done_q, done_d;
    logic                   advance_q, advance_d;
    logic                   hit_q, hit_d;
    logic                   miss_q, miss_d;

    logic                   en_rise;
    logic                   is_rest;
    logic                   key_match;
    logic                   do_hit;
    logic                   do_miss;
    logic [CNT_W-1:0]       note_cnt_inc;
    logic [31:0]            score_sum;
    grade_e                 grade_new;

    assign en_rise      = en && !en_prev_q;
    assign is_rest      = goal_note_q == NOTE_REST;
    assign note_cnt_inc = sat_inc8(note_cnt_q);

`ifdef SCORE_OCTAVE_MATCH_EN
    assign key_match = (key_note == goal_note_q) && (key_oct == goal_oct_q);
`else
    logic unused_oct;
    assign key_match  = key_note == goal_note_q;
    assign unused_oct = ^{key_oct, goal_oct_q};
`endif

    // Bonus point once the streak already stood at four or more.
    assign score_sum = 32'(score_q) + 32'(HIT_PTS)
                     + {31'd0, streak_q >= 4'd4};

    score_grade u_grade (
        .note_cnt (note_cnt_inc),
        .miss_cnt (miss_cnt_q),
        .grade    (grade_new)
    );

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        goal_note_d = goal_note_q;
        goal_oct_d  = goal_oct_q;
        goal_last_d = goal_last_q;
        note_cnt_d  = note_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        score_d     = score_q;
        streak_d    = streak_q;
        grade_d     = grade_q;
        done_d      = done_q;
        do_hit      = 1'b0;
        do_miss     = 1'b0;

        if (!en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en_rise) begin
                        state_d    = WAIT_GOAL;
                        score_d    = '0;
                        streak_d   = '0;
                        note_cnt_d = '0;
                        miss_cnt_d = '0;
                        done_d     = 1'b0;
                    end
                end
                WAIT_GOAL: begin
                    if (goal_vld) begin
                        goal_note_d = goal_note;
                        goal_oct_d  = goal_oct;
                        goal_last_d = goal_last;
                        win_d       = '0;
                        state_d     = ARMED;
                    end
                end
                ARMED: begin
                    // A key in the same cycle as the timeout wins.
                    if (key_vld) begin
                        if (is_rest) begin
                            do_miss = 1'b1;
                            state_d = RESULT;
                        end else if (key_match) begin
                            do_hit  = 1'b1;
                            state_d = RESULT;
                        end else begin
                            do_miss = 1'b1;
                        end
                    end else if (tick) begin
                        if (win_q == WIN_LAST) begin
                            do_hit  = is_rest;
                            do_miss = !is_rest;
                            state_d = RESULT;
                        end else begin
                            win_d = win_q + 1'b1;
                        end
                    end
                end
                RESULT: begin
                    note_cnt_d = note_cnt_inc;
                    if (goal_last_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        grade_d = grade_new;
                    end else begin
                        state_d = WAIT_GOAL;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (do_hit) begin
            streak_d = (streak_q == 4'hF) ? streak_q : streak_q + 1'b1;
            score_d  = (score_sum > 32'(SCORE_MAX)) ? SCORE_MAX
                                                    : score_sum[SCORE_W-1:0];
        end
        if (do_miss) begin
            streak_d   = '0;
            miss_cnt_d = sat_inc8(miss_cnt_q);
        end

        hit_d     = do_hit;
        miss_d    = do_miss;
        advance_d = state_d == RESULT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            en_prev_q   <= 1'b0;
            win_q       <= '0;
            goal_note_q <= '0;
            goal_oct_q  <= '0;
            goal_last_q <= 1'b0;
            note_cnt_q  <= '0;
            miss_cnt_q  <= '0;
            score_q     <= '0;
            streak_q    <= '0;
            grade_q     <= GRADE_D;
            done_q      <= 1'b0;
            advance_q   <= 1'b0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_prev_q   <= en;
            win_q       <= win_d;
            goal_note_q <= goal_note_d;
            goal_oct_q  <= goal_oct_d;
            goal_last_q <= goal_last_d;
            note_cnt_q  <= note_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            score_q     <= score_d;
            streak_q    <= streak_d;
            grade_q     <= grade_d;
            done_q      <= done_d;
            advance_q   <= advance_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
        end
    end

    assign advance    = advance_q;
    assign judge_hit  = hit_q;
    assign judge_miss = miss_q;
    assign score      = score_q;
    assign streak     = streak_q;
    assign grade      = grade_q;
    assign done       = done_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with TIMEOUT_TICKS=5, SCORE_W=4.
// Expected values are hand-computed from the scoring and grading rules.
module tb_score_keeper;

    localparam int OB = 3;
    localparam int NB = 4;

`ifdef SCORE_OCTAVE_MATCH_EN
    localparam logic OCT_HIT = 1'b0;
`else
    localparam logic OCT_HIT = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          rst, en, tick, key_vld, goal_vld, goal_last;
    logic [OB-1:0] key_oct, goal_oct;
    logic [NB-1:0] key_note, goal_note;
    logic          advance, judge_hit, judge_miss, done;
    logic [3:0]    score;
    logic [3:0]    streak;
    logic [1:0]    grade;

    int n_cmp = 0;
    int n_bad = 0;

    score_keeper #(
        .TIMEOUT_TICKS (5),
        .HIT_PTS       (2),
        .SCORE_W       (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .tick       (tick),
        .key_vld    (key_vld),
        .key_oct    (key_oct),
        .key_note   (key_note),
        .goal_vld   (goal_vld),
        .goal_oct   (goal_oct),
        .goal_note  (goal_note),
        .goal_last  (goal_last),
        .advance    (advance),
        .judge_hit  (judge_hit),
        .judge_miss (judge_miss),
        .score      (score),
        .streak     (streak),
        .grade      (grade),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_goal(input int n, input int o, input logic l);
        goal_vld  = 1'b1;
        goal_note = NB'(n);
        goal_oct  = OB'(o);
        goal_last = l;
    endtask

    task automatic present(input int n, input int o, input logic l);
        set_goal(n, o, l);
        cyc();
    endtask

    task automatic next_goal(input int n, input int o, input logic l);
        set_goal(n, o, l);
        cyc();
        cyc();
    endtask

    task automatic press(input int n, input int o);
        key_vld  = 1'b1;
        key_note = NB'(n);
        key_oct  = OB'(o);
        cyc();
        key_vld  = 1'b0;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
        end
    endtask

    task automatic finish_song();
        goal_vld = 1'b0;
        cyc();
    endtask

    task automatic restart();
        goal_vld = 1'b0;
        en = 1'b0;
        cyc();
        en = 1'b1;
        cyc();
    endtask

    initial begin
        int exp_score[7];
        exp_score = '{2, 4, 6, 8, 11, 14, 15};

        rst = 1'b1; en = 1'b0; tick = 1'b0; key_vld = 1'b0;
        goal_vld = 1'b0; goal_last = 1'b0;
        key_oct = '0; key_note = '0; goal_oct = '0; goal_note = '0;
        cyc();
        cyc();
        chk("rst_score", score, 0);
        chk("rst_streak", streak, 0);
        chk("rst_done", done, 0);
        chk("rst_adv", advance, 0);
        chk("rst_hit", judge_hit, 0);
        chk("rst_miss", judge_miss, 0);
        rst = 1'b0;

        // Clean run of three notes.
        restart();
        present(1, 4, 1'b0);
        press(1, 4);
        chk("c1_hit", judge_hit, 1);
        chk("c1_miss", judge_miss, 0);
        chk("c1_adv", advance, 1);
        chk("c1_score", score, 2);
        set_goal(3, 4, 1'b0);
        cyc();
        chk("c1_adv_pulse", advance, 0);
        chk("c1_hit_pulse", judge_hit, 0);
        cyc();
        press(3, 4);
        chk("c2_hit", judge_hit, 1);
        chk("c2_score", score, 4);
        next_goal(5, 4, 1'b1);
        press(5, 4);
        chk("c3_hit", judge_hit, 1);
        chk("c3_adv", advance, 1);
        chk("c3_score", score, 6);
        chk("c3_streak", streak, 3);
        finish_song();
        chk("c_done", done, 1);
        chk("c_grade", grade, 3);
        chk("c_adv_done", advance, 0);

        // Wrong key then right key, then three more hits.
        goal_vld = 1'b0;
        en = 1'b0;
        cyc();
        chk("idle_score_kept", score, 6);
        chk("idle_grade_kept", grade, 3);
        en = 1'b1;
        cyc();
        chk("w_score_clr", score, 0);
        chk("w_done_clr", done, 0);
        chk("w_streak_clr", streak, 0);
        present(4, 4, 1'b0);
        press(2, 4);
        chk("w_miss", judge_miss, 1);
        chk("w_hit0", judge_hit, 0);
        chk("w_adv0", advance, 0);
        press(4, 4);
        chk("w_hit", judge_hit, 1);
        chk("w_miss0", judge_miss, 0);
        chk("w_adv", advance, 1);
        chk("w_streak", streak, 1);
        next_goal(1, 0, 1'b0);
        press(1, 0);
        next_goal(2, 0, 1'b0);
        press(2, 0);
        next_goal(3, 0, 1'b1);
        press(3, 0);
        chk("w_score4", score, 8);
        chk("w_streak4", streak, 4);
        finish_song();
        chk("w_grade", grade, 1);

        // Timeouts, rest goals, collision, window kept across retry.
        restart();
        present(7, 2, 1'b0);
        ticks(4);
        chk("t_early", judge_miss, 0);
        ticks(1);
        chk("t_miss", judge_miss, 1);
        chk("t_hit0", judge_hit, 0);
        chk("t_adv", advance, 1);
        next_goal(0, 0, 1'b0);
        ticks(5);
        chk("rest_hit", judge_hit, 1);
        chk("rest_miss0", judge_miss, 0);
        chk("rest_score", score, 2);
        chk("rest_streak", streak, 1);
        next_goal(6, 0, 1'b0);
        ticks(4);
        tick = 1'b1;
        press(6, 0);
        tick = 1'b0;
        chk("col_hit", judge_hit, 1);
        chk("col_miss0", judge_miss, 0);
        chk("col_score", score, 4);
        next_goal(8, 0, 1'b0);
        ticks(2);
        press(2, 0);
        chk("retry_miss", judge_miss, 1);
        chk("retry_adv0", advance, 0);
        ticks(2);
        chk("retry_wait", judge_miss, 0);
        ticks(1);
        chk("retry_tmo", judge_miss, 1);
        chk("retry_adv", advance, 1);
        next_goal(0, 0, 1'b1);
        press(3, 0);
        chk("rest_key_miss", judge_miss, 1);
        chk("rest_key_hit0", judge_hit, 0);
        finish_song();
        chk("t_done", done, 1);
        chk("t_grade", grade, 0);
        chk("t_score", score, 4);

        // Streak bonus and 4-bit score saturation.
        restart();
        present(1, 0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            press(1, 0);
            chk($sformatf("sat_hit%0d", i), judge_hit, 1);
            chk($sformatf("sat_score%0d", i), score, exp_score[i]);
            if (i < 6) next_goal(1, 0, 1'b0);
        end
        chk("sat_streak", streak, 7);
        next_goal(2, 0, 1'b1);
        ticks(5);
        chk("sat_tmo", judge_miss, 1);
        chk("sat_streak0", streak, 0);
        chk("sat_hold", score, 15);
        finish_song();
        chk("sat_grade", grade, 2);

        // Reset in the middle of a window.
        restart();
        present(2, 0, 1'b0);
        press(2, 0);
        next_goal(3, 0, 1'b0);
        ticks(2);
        rst = 1'b1;
        key_vld = 1'b1;
        key_note = 4'd3;
        cyc();
        key_vld = 1'b0;
        chk("mr_score", score, 0);
        chk("mr_streak", streak, 0);
        chk("mr_hit", judge_hit, 0);
        chk("mr_adv", advance, 0);
        chk("mr_grade", grade, 0);
        chk("mr_done", done, 0);
        rst = 1'b0;

        // en dropped while armed.
        restart();
        present(2, 0, 1'b0);
        press(2, 0);
        next_goal(3, 0, 1'b0);
        en = 1'b0;
        press(3, 0);
        chk("ab_hit", judge_hit, 0);
        chk("ab_adv", advance, 0);
        cyc();
        chk("ab_adv2", advance, 0);
        chk("ab_score", score, 2);

        // Octave mismatch.
        restart();
        present(3, 4, 1'b0);
        press(3, 5);
        chk("oct_hit", judge_hit, 32'(OCT_HIT));
        chk("oct_miss", judge_miss, 32'(!OCT_HIT));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
